// File: rtl/fazyrv_cmp_seq_pkg.sv
// fazyrv_cmp_seq_pkg: branch funct3 codes, FSM states and the branch condition decode
package fazyrv_cmp_seq_pkg;
   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;
   typedef enum logic {S_IDLE, S_RUN} state_t;
   function automatic logic is_signed(input logic [2:0] f3);
      return f3[2:1] == 2'b10;
   endfunction
   // 010/011 are not branches and never take
   function automatic logic branch_taken(input logic [2:0] f3, input logic lo, input logic eq);
      return f3 == F3_BEQ ? eq : f3 == F3_BNE ? !eq : f3[2] ? (f3[0] ? !lo : lo) : 1'b0;
   endfunction
endpackage

// File: rtl/fazyrv_cmp_chunk.sv
// fazyrv_cmp_chunk: combinational chunk compare; inv_msb flips both MSBs for signed top chunks
module fazyrv_cmp_chunk #(
   parameter int W = 2
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         inv_msb,
   output logic         lt,
   output logic         gt
);
   logic [W-1:0] m, aa, bb;
   assign m  = W'(inv_msb) << (W - 1);
   assign aa = a ^ m;
   assign bb = b ^ m;
   assign lt = aa < bb;
   assign gt = aa > bb;
endmodule

// File: rtl/fazyrv_cmp_seq.sv
// fazyrv_cmp_seq: chunk-serial LSB-first comparator resolving RISC-V branch conditions
module fazyrv_cmp_seq
   import fazyrv_cmp_seq_pkg::*;
#(
   parameter int BWIDTH = 2,
   parameter int WORDW  = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic              valid_i,
   input  logic [2:0]        funct3_i,
   input  logic [BWIDTH-1:0] a_i,
   input  logic [BWIDTH-1:0] b_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              lo_o,
   output logic              gr_o,
   output logic              eq_o,
   output logic              taken_o
);
   localparam int NCHUNK = WORDW / BWIDTH;
   localparam int CNTW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
   localparam logic [CNTW-1:0] LAST = CNTW'(NCHUNK - 1);
   state_t state, state_n;
   logic [CNTW-1:0] cnt, cnt_n;
   logic [2:0] f3_q, f3;
   logic r_lt, r_gt, go, acc, fin, c_lt, c_gt, lt_n, gt_n;
   assign go  = start_i & valid_i;
   assign acc = go | (valid_i & (state == S_RUN));
   assign fin = acc & ((go ? '0 : cnt) == LAST);
   assign f3  = go ? funct3_i : f3_q;
   fazyrv_cmp_chunk #(.W(BWIDTH)) u_chunk (
      .a       (a_i),
      .b       (b_i),
      .inv_msb (fin & is_signed(f3)),
      .lt      (c_lt),
      .gt      (c_gt)
   );
   // a differing higher chunk overrides; a start chunk ignores earlier history
   assign lt_n   = c_lt | (!c_gt & !go & r_lt);
   assign gt_n   = c_gt | (!c_lt & !go & r_gt);
   assign busy_o = state == S_RUN;
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      if (go) begin
         state_n = NCHUNK > 1 ? S_RUN : S_IDLE;
         cnt_n   = NCHUNK > 1 ? CNTW'(1) : '0;
      end else if (acc) begin
         state_n = fin ? S_IDLE : S_RUN;
         cnt_n   = fin ? '0 : cnt + 1'b1;
      end
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state   <= S_IDLE;
         cnt     <= '0;
         f3_q    <= '0;
         r_lt    <= 1'b0;
         r_gt    <= 1'b0;
         done_o  <= 1'b0;
         lo_o    <= 1'b0;
         gr_o    <= 1'b0;
         eq_o    <= 1'b0;
         taken_o <= 1'b0;
      end else begin
         state  <= state_n;
         cnt    <= cnt_n;
         done_o <= fin;
         if (go) f3_q <= funct3_i;
         if (acc) begin
            r_lt <= lt_n;
            r_gt <= gt_n;
         end
         if (fin) begin
            lo_o    <= lt_n;
            gr_o    <= gt_n;
            eq_o    <= !lt_n & !gt_n;
            taken_o <= branch_taken(f3, lt_n, !lt_n & !gt_n);
         end
      end
   end
endmodule

// File: tb/tb_fazyrv_cmp_seq.sv
// tb_fazyrv_cmp_seq: table-driven and random compares with a done-time scoreboard
module tb_fazyrv_cmp_seq;
   import fazyrv_cmp_seq_pkg::*;
   localparam int NC = 8;
   logic clk = 1'b0, rst = 1'b1, start = 1'b0, valid = 1'b0;
   logic [2:0] f3 = 3'b0;
   logic [3:0] a = 4'b0, b = 4'b0;
   logic busy, done, lo, gr, eq, tk;
   int cyc = 0;
   int n_cmp = 0, n_bad = 0;
   typedef struct {logic lo, gr, eq, tk; int cyc;} exp_t;
   typedef struct {logic [2:0] f3; logic [31:0] a, b; logic lo, gr, eq, tk;} vec_t;
   exp_t sbq[$];
   fazyrv_cmp_seq #(.BWIDTH(4), .WORDW(32)) dut (
      .clk_i    (clk),
      .rst_i    (rst),
      .start_i  (start),
      .valid_i  (valid),
      .funct3_i (f3),
      .a_i      (a),
      .b_i      (b),
      .busy_o   (busy),
      .done_o   (done),
      .lo_o     (lo),
      .gr_o     (gr),
      .eq_o     (eq),
      .taken_o  (tk)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask
   always @(negedge clk) begin
      if (done) begin
         if (sbq.size() == 0) chk("spurious_done", done, 1'b0);
         else begin
            exp_t e;
            e = sbq.pop_front();
            chk("lo", lo, e.lo);
            chk("gr", gr, e.gr);
            chk("eq", eq, e.eq);
            chk("taken", tk, e.tk);
            chk("done_cycle", cyc, e.cyc);
         end
      end
   end
   function automatic vec_t mk(input logic [2:0] fn, input logic [31:0] av, input logic [31:0] bv);
      vec_t v;
      logic sg;
      sg = fn[2:1] == 2'b10;
      v.f3 = fn; v.a = av; v.b = bv;
      v.lo = sg ? ($signed(av) < $signed(bv)) : (av < bv);
      v.gr = sg ? ($signed(av) > $signed(bv)) : (av > bv);
      v.eq = av == bv;
      v.tk = fn == 3'b000 ? v.eq : fn == 3'b001 ? !v.eq : fn[2] ? (fn[0] ? !v.lo : v.lo) : 1'b0;
      return v;
   endfunction
   // drives n chunks starting at chunk 0; funct3 is scrambled after the start chunk
   task automatic drive_op(input vec_t v, input int n, input int gap_at, input int gap_n, input logic push);
      exp_t e;
      if (push) begin
         e.lo = v.lo; e.gr = v.gr; e.eq = v.eq; e.tk = v.tk;
         e.cyc = cyc + NC + gap_n;
         sbq.push_back(e);
      end
      for (int i = 0; i < n; i++) begin
         start = i == 0;
         valid = 1'b1;
         f3 = i == 0 ? v.f3 : ~v.f3;
         a = v.a[4*i +: 4];
         b = v.b[4*i +: 4];
         @(posedge clk); #1;
         if (i == gap_at) begin
            for (int g = 0; g < gap_n; g++) begin
               start = 1'b0; valid = 1'b0;
               a = 4'($urandom); b = 4'($urandom);
               @(posedge clk); #1;
               chk("busy_gap", busy, 1'b1);
            end
         end
      end
      start = 1'b0;
      valid = 1'b0;
   endtask
   initial begin
      vec_t tv[12];
      vec_t v;
      logic [2:0] f3s[7];
      logic [31:0] av, bv;
      f3s = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b110, 3'b111};
      tv[0]  = '{F3_BLTU, 32'h1000_0000, 32'h0FFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0};
      tv[1]  = '{F3_BLT,  32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0, 1'b0, 1'b1};
      tv[2]  = '{F3_BLTU, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 1'b0, 1'b0};
      tv[3]  = '{F3_BGE,  32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0, 1'b0, 1'b0};
      tv[4]  = '{F3_BEQ,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1, 1'b1};
      tv[5]  = '{F3_BNE,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1, 1'b0};
      tv[6]  = '{3'b010,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1, 1'b0};
      tv[7]  = '{F3_BGEU, 32'h0000_0005, 32'h0000_0009, 1'b1, 1'b0, 1'b0, 1'b0};
      tv[8]  = '{F3_BLT,  32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b1};
      tv[9]  = '{F3_BGE,  32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1};
      tv[10] = '{F3_BNE,  32'h1234_5678, 32'h1234_5679, 1'b1, 1'b0, 1'b0, 1'b1};
      tv[11] = '{F3_BLTU, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0};
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_lo", lo, 1'b0);
      chk("rst_gr", gr, 1'b0);
      chk("rst_eq", eq, 1'b0);
      chk("rst_taken", tk, 1'b0);
      rst = 1'b0;
      for (int i = 0; i < 12; i++) drive_op(tv[i], NC, -1, 0, 1'b1);
      for (int i = 0; i < 16; i++) begin
         av = $urandom;
         bv = $urandom_range(0, 3) == 0 ? av : ($urandom_range(0, 1) == 1 ? (av ^ (32'h1 << $urandom_range(0, 31))) : $urandom);
         drive_op(mk(f3s[$urandom_range(0, 6)], av, bv), NC, -1, 0, 1'b1);
      end
      start = 1'b0; valid = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
         chk("idle_valid_busy", busy, 1'b0);
      end
      valid = 1'b0;
      drive_op(mk(F3_BLTU, 32'd5, 32'd9), NC, 2, 3, 1'b1);
      drive_op(mk(F3_BNE, 32'h1111_1111, 32'h2222_2222), 5, -1, 0, 1'b0);
      chk("held_lo", lo, 1'b1);
      chk("held_busy", busy, 1'b1);
      drive_op(mk(F3_BEQ, 32'd7, 32'd7), NC, -1, 0, 1'b1);
      drive_op(mk(F3_BLT, 32'hAAAA_5555, 32'h5555_AAAA), 3, -1, 0, 1'b0);
      rst = 1'b1; valid = 1'b1; a = 4'h3; b = 4'hC;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_done", done, 1'b0);
      chk("mid_rst_lo", lo, 1'b0);
      chk("mid_rst_gr", gr, 1'b0);
      chk("mid_rst_eq", eq, 1'b0);
      chk("mid_rst_taken", tk, 1'b0);
      repeat (4) begin
         @(posedge clk); #1;
         chk("post_rst_busy", busy, 1'b0);
      end
      valid = 1'b0;
      drive_op(mk(F3_BGEU, 32'h0000_0100, 32'h0000_00FF), NC, -1, 0, 1'b1);
      repeat (12) @(posedge clk);
      #1;
      chk("sb_empty", sbq.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
